// File: rtl/pit.sv
// ---------------------------------------------------------------------------
// pit : 32-bit programmable interval timer.
//
// A period register, a down-counter and an interrupt flop. State advances
// only on clk edges qualified by clk_en ("ticks"). Writing a non-zero period
// N makes interrupt pulse for one tick every N ticks. N=1 keeps it high
// continuously, and N=0 disables the timer. A write restarts the count
// immediately. Reset clears everything and leaves the timer disabled.
// ---------------------------------------------------------------------------
module pit (
   input  logic        clk,
   input  logic        clk_en,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic        interrupt,
   input  logic        rst
);

   logic [31:0] r_period;
   logic [31:0] r_counter;
   logic        r_interrupt;

   logic [31:0] w_period_nxt;
   logic [31:0] w_counter_nxt;
   logic        w_interrupt_nxt;
   logic        w_disabled;
   logic        w_expire;

   assign w_disabled = (r_period == 32'd0);
   // counter<=1 also covers a stray 0 count, so there is never a borrow past 0
   assign w_expire   = (r_counter <= 32'd1);

   // Next-state selection for one enabled tick: write > disabled > expiry > count
   always_comb begin
      w_period_nxt    = r_period;
      w_counter_nxt   = r_counter;
      w_interrupt_nxt = 1'b0;
      if (we) begin
         w_period_nxt    = wdata;
         w_counter_nxt   = wdata;
         w_interrupt_nxt = 1'b0;
      end else if (w_disabled) begin
         w_period_nxt    = r_period;
         w_counter_nxt   = r_counter;
         w_interrupt_nxt = 1'b0;
      end else if (w_expire) begin
         w_period_nxt    = r_period;
         w_counter_nxt   = r_period;
         w_interrupt_nxt = 1'b1;
      end else begin
         w_period_nxt    = r_period;
         w_counter_nxt   = r_counter - 32'd1;
         w_interrupt_nxt = 1'b0;
      end
   end

   // Timer state: synchronous reset first, then update only on enabled ticks
   always_ff @(posedge clk) begin
      if (rst) begin
         r_period    <= 32'd0;
         r_counter   <= 32'd0;
         r_interrupt <= 1'b0;
      end else if (clk_en) begin
         r_period    <= w_period_nxt;
         r_counter   <= w_counter_nxt;
         r_interrupt <= w_interrupt_nxt;
      end else begin
         r_period    <= r_period;
         r_counter   <= r_counter;
         r_interrupt <= r_interrupt;
      end
   end

   assign interrupt = r_interrupt;

endmodule

// File: tb/tb_pit.sv
// ---------------------------------------------------------------------------
// tb_pit : directed, table-driven bench for the pit interval timer.
// Each vector is applied for one clk cycle, and interrupt is compared 1 ns
// after the rising edge with the hand-computed value for that edge.
// ---------------------------------------------------------------------------
module tb_pit;

   logic        clk;
   logic        clk_en;
   logic        we;
   logic [31:0] wdata;
   logic        interrupt;
   logic        rst;

   int n_tests;
   int n_fail;

   typedef struct {
      logic        rst;
      logic        en;
      logic        we;
      logic [31:0] wdata;
      logic        exp_int;
      string       name;
   } vec_t;

   vec_t vecs[256];
   int   n_vecs;

   pit dut (
      .clk       (clk),
      .clk_en    (clk_en),
      .we        (we),
      .wdata     (wdata),
      .interrupt (interrupt),
      .rst       (rst)
   );

   // 100 MHz free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic add(input logic r, input logic e, input logic w,
                      input logic [31:0] d, input logic x, input string nm);
      vecs[n_vecs].rst     = r;
      vecs[n_vecs].en      = e;
      vecs[n_vecs].we      = w;
      vecs[n_vecs].wdata   = d;
      vecs[n_vecs].exp_int = x;
      vecs[n_vecs].name    = nm;
      n_vecs++;
   endtask

   // apply inputs for one clk cycle and check interrupt after the edge
   task automatic step(input logic r, input logic e, input logic w,
                       input logic [31:0] d, input logic x, input string nm);
      rst    = r;
      clk_en = e;
      we     = w;
      wdata  = d;
      @(posedge clk);
      #1;
      n_tests++;
      if (interrupt !== x) begin
         n_fail++;
         $display("FAIL %s: interrupt=%b expected=%b at %0t", nm, interrupt, x, $time);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      n_vecs  = 0;
      rst     = 1'b1;
      clk_en  = 1'b0;
      we      = 1'b0;
      wdata   = 32'd0;

      // ---------------- vector table ----------------
      // reset, then 20 ticks with no write: timer disabled
      add(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, "reset");
      for (int i = 0; i < 20; i++) add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "idle_after_reset");

      // write 3: expiry on ticks 3, 6, 9; clk_en=0 cycles hold the pulse and ignore we
      add(1'b0, 1'b1, 1'b1, 32'd3, 1'b0, "write3");
      add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "p3_tick1");
      add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "p3_tick2");
      add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, "p3_tick3");
      add(1'b0, 1'b0, 1'b1, 32'd7, 1'b1, "p3_hold_we_ignored");
      add(1'b0, 1'b0, 1'b1, 32'd7, 1'b1, "p3_hold_we_ignored");
      add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "p3_tick4");
      add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "p3_tick5");
      add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, "p3_tick6");
      add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "p3_tick7");
      add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "p3_tick8");
      add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, "p3_tick9");

      // write 5, 3 ticks, write 2: expiry 2 ticks later; then write 0 disables
      add(1'b0, 1'b1, 1'b1, 32'd5, 1'b0, "write5");
      for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "p5_count");
      add(1'b0, 1'b1, 1'b1, 32'd2, 1'b0, "rewrite2");
      add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "p2_tick1");
      add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, "p2_tick2");
      add(1'b0, 1'b1, 1'b1, 32'd0, 1'b0, "write0");
      for (int i = 0; i < 10; i++) add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "disabled_after_write0");

      // write 1: continuous high; reset with clk_en=0 still clears it
      add(1'b0, 1'b1, 1'b1, 32'd1, 1'b0, "write1");
      for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, "p1_continuous");
      add(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, "reset_no_en");
      for (int i = 0; i < 10; i++) add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "disabled_after_reset");

      for (int i = 0; i < n_vecs; i++)
         step(vecs[i].rst, vecs[i].en, vecs[i].we, vecs[i].wdata, vecs[i].exp_int, vecs[i].name);

      // ---------------- hand sequence: clk_en every 4th cycle, write 2 ----------------
      step(1'b0, 1'b1, 1'b1, 32'd2, 1'b0, "slow_write2");
      for (int c = 1; c < 24; c++) begin
         int  k;
         logic x;
         k = c / 4;
         x = (k >= 1) && ((k % 2) == 0);
         if ((c % 4) == 0)
            step(1'b0, 1'b1, 1'b0, 32'd0, x, "slow_tick");
         else
            step(1'b0, 1'b0, c[0], 32'd9, x, "slow_hold");
      end

      // ---------------- hand sequence: max period, then reset beats write ----------------
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, "write_max");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "max_no_early_expiry");
      step(1'b1, 1'b1, 1'b1, 32'd4, 1'b0, "reset_beats_write");
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "disabled_after_reset_write");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
